// File: rtl/tag_scan_pkg.sv
// Shared types and constants for the tag scan unit.
// Holds the FSM state encoding and the index width.
package tag_scan_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESP
  } state_e;

endpackage

// File: rtl/tag_scan_if.sv
// Lookup request/response handshake bundle.
// master: requester side; slave: the scan unit.
interface tag_scan_if #(
  parameter int TAG_W = 3
);
  import tag_scan_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_key;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic [IDX_W-1:0] resp_idx;

  modport master (
    output req_valid,
    output req_key,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_hit,
    input  resp_idx
  );

  modport slave (
    input  req_valid,
    input  req_key,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_hit,
    output resp_idx
  );

endinterface

// File: rtl/comp3.sv
// 3-bit equality comparator.
// Ports: a, b operands; eq high when a == b.
module comp3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/tag_scan_unit.sv
// Sequential tag table lookup: one entry compared per cycle.
// Ports: clk, rst, table write (wr_*), clear, bus (req/resp).
module tag_scan_unit
  import tag_scan_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clear,
  tag_scan_if.slave        bus
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_ENTRIES - 1);

  logic [N_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [N_ENTRIES];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] key_q, key_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic wr_ok;
  logic tag_eq;
  logic match;

  assign wr_ok = int'(wr_idx) < N_ENTRIES;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en && wr_ok) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_en && wr_ok) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  comp3 u_comp (
    .a  (3'(tag_q[ptr_q])),
    .b  (3'(key_q)),
    .eq (tag_eq)
  );

  // Comparator only sees tags; validity gates it here.
  assign match = valid_q[ptr_q] && tag_eq;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    key_d   = key_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          key_d   = bus.req_key;
          ptr_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          idx_d   = ptr_q;
          state_d = S_RESP;
        end else if (ptr_q == LAST) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = S_RESP;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      key_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake outputs drop as soon as rst rises.
  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.resp_valid = (state_q == S_RESP) && !rst;
  assign bus.resp_hit   = hit_q;
  assign bus.resp_idx   = idx_q;

endmodule

// File: tb/tb_tag_scan_unit.sv
// Directed bench for tag_scan_unit with a result scoreboard.
// Table model predicts hit/index/latency per lookup.
module tb_tag_scan_unit;

  localparam int N = 8;

  typedef struct {
    logic       hit;
    logic [2:0] idx;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [2:0] wr_tag;
  logic       clear;

  tag_scan_if #(.TAG_W(3)) bus ();

  tag_scan_unit #(
    .N_ENTRIES (N),
    .TAG_W     (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_tag (wr_tag),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb [$];
  logic       mvalid [N];
  logic [2:0] mtag   [N];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [2:0] key);
    exp_t e;
    e.hit = 1'b0;
    e.idx = 3'd0;
    e.lat = N + 1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mvalid[i] && mtag[i] == key) begin
        e.hit = 1'b1;
        e.idx = 3'(i);
        e.lat = i + 2;
      end
    end
    return e;
  endfunction

  task automatic tbl(input logic we, input logic [2:0] idx,
                     input logic [2:0] tg, input logic clr);
    @(negedge clk);
    wr_en  = we;
    wr_idx = idx;
    wr_tag = tg;
    clear  = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    clear = 1'b0;
    if (clr) begin
      for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    end else if (we && int'(idx) < N) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
  endtask

  task automatic lookup(input logic [2:0] key, input int hold);
    exp_t e, g;
    int   cyc;
    bit   seen;
    e = predict(key);
    sb.push_back(e);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_key   = key;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_key   = ~key;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid) seen = 1;
    end
    check("resp_seen", 32'(seen), 1);
    g = sb.pop_front();
    if (seen) begin
      check("resp_hit", 32'(bus.resp_hit), 32'(g.hit));
      check("resp_idx", 32'(bus.resp_idx), 32'(g.idx));
      check("latency", 32'(cyc), 32'(g.lat));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.resp_valid), 1);
        check("hold_hit", 32'(bus.resp_hit), 32'(g.hit));
        check("hold_idx", 32'(bus.resp_idx), 32'(g.idx));
        check("hold_rdy", 32'(bus.req_ready), 0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      check("post_valid", 32'(bus.resp_valid), 0);
      check("post_rdy", 32'(bus.req_ready), 1);
      check("post_hit", 32'(bus.resp_hit), 32'(g.hit));
      check("post_idx", 32'(bus.resp_idx), 32'(g.idx));
    end
  endtask

  task automatic abort_lookup(input logic [2:0] key);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_key   = key;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("abort_scan_valid", 32'(bus.resp_valid), 0);
    end
    rst = 1'b1;
    #1;
    check("abort_rst_rdy", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(bus.resp_valid), 0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    wr_en          = 1'b0;
    wr_idx         = 3'd0;
    wr_tag         = 3'd0;
    clear          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_key    = 3'd0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = 3'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 1);
    check("idle_resp_valid", 32'(bus.resp_valid), 0);
    check("idle_hit", 32'(bus.resp_hit), 0);
    check("idle_idx", 32'(bus.resp_idx), 0);

    tbl(1'b1, 3'd5, 3'b110, 1'b0);
    lookup(3'b110, 0);

    tbl(1'b1, 3'd2, 3'b011, 1'b0);
    tbl(1'b1, 3'd6, 3'b011, 1'b0);
    lookup(3'b011, 0);

    tbl(1'b0, 3'd0, 3'd0, 1'b1);
    lookup(3'b000, 0);

    tbl(1'b1, 3'd1, 3'b100, 1'b0);
    tbl(1'b1, 3'd1, 3'b100, 1'b1);
    lookup(3'b100, 0);

    tbl(1'b1, 3'd0, 3'b111, 1'b0);
    lookup(3'b111, 5);

    tbl(1'b1, 3'd3, 3'b010, 1'b0);
    lookup(3'b010, 0);

    tbl(1'b1, 3'd7, 3'b101, 1'b0);
    abort_lookup(3'b101);
    lookup(3'b101, 0);
    lookup(3'b111, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
